// File: rtl/regfile_mrw_if.sv
// ============================================================================
//  Module      : regfile_mrw_if
//  Description : Bundled read/write port signals for the multi-port register
//                file, with master (datapath) and slave (register file) views.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface regfile_mrw_if #(
  parameter int ADDR_BITS = 5,
  parameter int WIDTH     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 2
);
  logic [NWRITE-1:0]           we;
  logic [NWRITE*ADDR_BITS-1:0] wa;
  logic [NWRITE*WIDTH-1:0]     wd;
  logic [NREAD*ADDR_BITS-1:0]  ra;
  logic [NREAD*WIDTH-1:0]      rd;
  logic                        wr_conflict;
  logic [ADDR_BITS-1:0]        conflict_addr;

  modport master (
    output we, wa, wd, ra,
    input  rd, wr_conflict, conflict_addr
  );

  modport slave (
    input  we, wa, wd, ra,
    output rd, wr_conflict, conflict_addr
  );
endinterface

`default_nettype wire

// File: rtl/regfile_mrw.sv
// ============================================================================
//  Module      : regfile_mrw
//  Description : Parametrised register file with NREAD combinational read
//                ports, NWRITE clocked write ports (lowest port wins), an
//                optional hardwired zero entry, optional write-to-read bypass
//                and a registered same-address write-conflict report.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module regfile_mrw #(
  parameter int ADDR_BITS = 5,
  parameter int WIDTH     = 32,
  parameter int NREAD     = 2,
  parameter int NWRITE    = 2,
  parameter int ZERO_REG  = 1,
  parameter int BYPASS    = 1
) (
  input  wire logic      clk,
  input  wire logic      rst,
  regfile_mrw_if.slave   bus
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0]     mem [DEPTH];
  logic [ADDR_BITS-1:0] wa_a [NWRITE];
  logic [WIDTH-1:0]     wd_a [NWRITE];
  logic [NWRITE-1:0]    wr_ok;

  logic                 conflict_found;
  logic [ADDR_BITS-1:0] conflict_min;
  logic                 conflict_q;
  logic [ADDR_BITS-1:0] conflict_addr_q;

  // Unpack write ports; a write to entry 0 is not a real write when it is hardwired
  for (genvar i = 0; i < NWRITE; i++) begin : g_wport
    assign wa_a[i]  = bus.wa[i*ADDR_BITS +: ADDR_BITS];
    assign wd_a[i]  = bus.wd[i*WIDTH +: WIDTH];
    assign wr_ok[i] = bus.we[i] && !((ZERO_REG != 0) && (wa_a[i] == '0));
  end

  // Storage update: iterate from highest port down so the lowest index lands last and wins
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int e = 0; e < DEPTH; e++) begin
        mem[e] <= '0;
      end
    end else begin
      for (int i = NWRITE - 1; i >= 0; i--) begin
        if (wr_ok[i]) begin
          mem[wa_a[i]] <= wd_a[i];
        end
      end
    end
  end

  // Read ports: stored value, overridden by the winning same-cycle write, then by the zero entry
  for (genvar j = 0; j < NREAD; j++) begin : g_rport
    logic [ADDR_BITS-1:0] addr;
    logic [WIDTH-1:0]     data;

    assign addr = bus.ra[j*ADDR_BITS +: ADDR_BITS];

    // Bypass is suppressed under reset because those writes are discarded
    always_comb begin
      data = mem[addr];
      if ((BYPASS != 0) && !rst) begin
        for (int i = NWRITE - 1; i >= 0; i--) begin
          if (bus.we[i] && (wa_a[i] == addr)) begin
            data = wd_a[i];
          end
        end
      end
      if ((ZERO_REG != 0) && (addr == '0)) begin
        data = '0;
      end
    end

    assign bus.rd[j*WIDTH +: WIDTH] = data;
  end

  // Pairwise search for enabled writes to the same writable entry, keeping the lowest address
  always_comb begin
    conflict_found = 1'b0;
    conflict_min   = '0;
    for (int i = 0; i < NWRITE; i++) begin
      for (int k = i + 1; k < NWRITE; k++) begin
        if (wr_ok[i] && wr_ok[k] && (wa_a[i] == wa_a[k])) begin
          if (!conflict_found || (wa_a[i] < conflict_min)) begin
            conflict_min = wa_a[i];
          end
          conflict_found = 1'b1;
        end
      end
    end
  end

  // Conflict report register; the address holds across conflict-free cycles
  always_ff @(posedge clk) begin
    if (rst) begin
      conflict_q      <= 1'b0;
      conflict_addr_q <= '0;
    end else begin
      conflict_q <= conflict_found;
      if (conflict_found) begin
        conflict_addr_q <= conflict_min;
      end
    end
  end

  assign bus.wr_conflict   = conflict_q;
  assign bus.conflict_addr = conflict_addr_q;

endmodule

`default_nettype wire

// File: doc/regfile_mrw.md
Name: regfile_mrw

Overview:
- Parametrised multi-port register file: NREAD combinational read ports and NWRITE clocked write ports over 2**ADDR_BITS entries of WIDTH bits.
- Successor to the fixed 32x32, 2R/2W register file.
- Adds synchronous reset, a deterministic write-priority rule, an optional hardwired zero register, optional write-to-read bypass, and a registered write-conflict report for the pipeline hazard logic.
- Sits in the datapath between decode (read addresses) and writeback (write ports).

Parameters:
- ADDR_BITS, 5: address width; DEPTH = 2**ADDR_BITS entries.
- WIDTH, 32: data width per entry.
- NREAD, 2: number of read ports (1..8).
- NWRITE, 2: number of write ports (1..4).
- ZERO_REG, 1: 1 = entry 0 always reads 0 and ignores writes; 0 = entry 0 is ordinary storage.
- BYPASS, 1: 1 = a read of an entry being written this cycle returns the winning write data; 0 = the read returns the stored value.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset; synchronous, active-high.
- we  in  NWRITE  write enable per port; port i is bit i.
- wa  in  NWRITE*ADDR_BITS  write addresses; port i is at bits [i*ADDR_BITS +: ADDR_BITS].
- wd  in  NWRITE*WIDTH  write data; port i is at bits [i*WIDTH +: WIDTH].
- ra  in  NREAD*ADDR_BITS  read addresses, packed the same way as wa.
- rd  out  NREAD*WIDTH  read data, packed the same way as wd.
- wr_conflict  out  1  registered: in the previous cycle, at least two enabled write ports targeted the same writable entry.
- conflict_addr  out  ADDR_BITS  registered: the lowest conflicting address from the previous cycle; holds its value when no conflict occurs.

Behaviour:
- Clocking and reset:
  - Single clock domain; all state updates on the rising edge of clk.
  - rst is synchronous and active-high.
  - While rst=1 at an edge: every entry is set to 0, wr_conflict is set to 0, conflict_addr is set to 0, and all writes in that cycle are discarded.
  - Reset mid-operation: a write presented in the same cycle as rst is lost; no partial update.
- Write:
  - A port whose we bit is 1 updates entry wa[i] with wd[i] at the edge. Write latency is 1 cycle.
  - Priority: if several enabled ports target the same entry, the lowest port index wins. The other ports' data for that entry is dropped.
  - Writes from different ports to different entries all complete in the same cycle.
  - With ZERO_REG=1, writes to entry 0 are dropped and are never counted as a conflict.
- Read:
  - Combinational, 0-cycle latency: rd[j] = entry[ra[j]].
  - With ZERO_REG=1, rd[j] = 0 whenever ra[j]=0, regardless of bypass.
  - With BYPASS=1, if any enabled write port targets ra[j] in the current cycle, rd[j] equals the data of the lowest-index such port.
  - With BYPASS=0, rd[j] returns the pre-edge stored value; the new value is visible from the next cycle.
  - During a cycle with rst=1, reads return the current storage; after the reset edge they return 0.
- Conflict reporting:
  - Each cycle, for every pair of ports (i<k) with both enabled and wa[i]=wa[k] (and the address not 0 when ZERO_REG=1), a conflict is flagged.
  - At the next edge: wr_conflict is set to 1 if any conflict was flagged in that cycle, otherwise 0.
  - conflict_addr loads the smallest conflicting address when wr_conflict is set; otherwise it is unchanged.
- Boundaries:
  - Address DEPTH-1 is valid; there is no out-of-range address.
  - NWRITE=1: wr_conflict is constantly 0.
  - All ports enabled to the same address: port 0 wins; wr_conflict=1 on the next cycle.

Test Plan:
- Reset: write 0xDEADBEEF to entry 7, then assert rst for 1 cycle -> rd for ra=7 reads 0x00000000; wr_conflict=0; conflict_addr=0.
- Parallel writes: port0 writes 0x11111111 to entry 3, port1 writes 0x22222222 to entry 9 in the same cycle -> next cycle ra0=3 reads 0x11111111 and ra1=9 reads 0x22222222; wr_conflict=0.
- Conflict and priority: port0 writes 0xAAAA0000 and port1 writes 0x0000BBBB, both to entry 12 -> entry 12 reads 0xAAAA0000; one cycle later wr_conflict=1 and conflict_addr=12; wr_conflict=0 on the following idle cycle while conflict_addr stays 12.
- Zero register (ZERO_REG=1): both ports write 0xFFFFFFFF to entry 0 -> ra=0 reads 0; wr_conflict stays 0. With ZERO_REG=0, the same stimulus gives 0xFFFFFFFF and wr_conflict=1.
- Bypass (BYPASS=1): entry 5 holds 0x5; in the same cycle port1 writes 0x77 to entry 5 and ra0=5 -> rd0=0x77 in that cycle. With BYPASS=0 -> rd0=0x5 in that cycle and 0x77 in the next.
- Reset mid-write plus boundary address: rst=1 while port0 writes 0x1234 to entry 31 -> entry 31 reads 0 after the edge. Then write 0x1234 to entry 31 with rst=0 -> it reads 0x1234.
